// File: rtl/proc_control_unit_if.sv
// Control bundle between the sequencer and the bus datapath.
// The datapath side is master: it supplies run/din and consumes the enables.
interface proc_control_unit_if #(
  parameter int N_REGS = 8
);
  logic              run;
  logic [15:0]       din;
  logic              ir_in;
  logic [N_REGS-1:0] r_in;
  logic [N_REGS-1:0] r_out;
  logic              din_out;
  logic              g_out;
  logic              a_in;
  logic              g_in;
  logic              addsub;
  logic              done;
  logic              busy;

  modport master (
    output run, din,
    input  ir_in, r_in, r_out, din_out, g_out,
    input  a_in, g_in, addsub, done, busy
  );

  modport slave (
    input  run, din,
    output ir_in, r_in, r_out, din_out, g_out,
    output a_in, g_in, addsub, done, busy
  );
endinterface

// File: rtl/proc_control_unit.sv
// T0-T3 sequencer for the 16-bit bus processor.
// Holds the 9-bit IR and decodes all bus/ALU enables from step and IR.
module proc_control_unit #(
  parameter int N_REGS = 8
) (
  input  logic              clock,
  input  logic              resetn,
  proc_control_unit_if.slave bus
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  step_e      state_q, state_d;
  logic [8:0] ir_q, ir_d;

  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       op_mv;
  logic       op_mvi;
  logic       op_alu;
  logic       unused_din;

  assign opcode     = ir_q[8:6];
  assign rx         = ir_q[5:3];
  assign ry         = ir_q[2:0];
  assign op_mv      = (opcode == 3'b000);
  assign op_mvi     = (opcode == 3'b001);
  assign op_alu     = (opcode == 3'b010) || (opcode == 3'b011);
  assign unused_din = ^bus.din[6:0];

  function automatic logic [N_REGS-1:0] onehot(input logic [2:0] idx);
    logic [N_REGS-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (idx == 3'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      T0: begin
        if (bus.run) begin
          ir_d    = bus.din[15:7];
          state_d = T1;
        end
      end
      T1:      state_d = op_alu ? T2 : T0;
      T2:      state_d = T3;
      T3:      state_d = T0;
      default: state_d = T0;
    endcase
  end

  // Every bus source is gated by step, so T0 never drives the bus.
  always_comb begin
    bus.ir_in   = 1'b0;
    bus.r_in    = '0;
    bus.r_out   = '0;
    bus.din_out = 1'b0;
    bus.g_out   = 1'b0;
    bus.a_in    = 1'b0;
    bus.g_in    = 1'b0;
    bus.addsub  = 1'b0;
    bus.done    = 1'b0;
    bus.busy    = (state_q != T0);
    unique case (state_q)
      T0: bus.ir_in = bus.run;
      T1: begin
        unique case (1'b1)
          op_mv: begin
            bus.r_out = onehot(ry);
            bus.r_in  = onehot(rx);
            bus.done  = 1'b1;
          end
          op_mvi: begin
            bus.din_out = 1'b1;
            bus.r_in    = onehot(rx);
            bus.done    = 1'b1;
          end
          op_alu: begin
            bus.r_out = onehot(rx);
            bus.a_in  = 1'b1;
          end
          default: bus.done = 1'b1;
        endcase
      end
      T2: begin
        bus.r_out  = onehot(ry);
        bus.g_in   = 1'b1;
        bus.addsub = (opcode == 3'b011);
      end
      T3: begin
        bus.g_out = 1'b1;
        bus.r_in  = onehot(rx);
        bus.done  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Bench for proc_control_unit: micro-op table model, datapath model,
// per-cycle output compare plus literal spot checks.
module tb_proc_control_unit;

  logic clock;
  logic resetn;

  proc_control_unit_if #(.N_REGS(8)) bus ();

  proc_control_unit #(.N_REGS(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       ir_in;
    logic [7:0] r_in;
    logic [7:0] r_out;
    logic       din_out;
    logic       g_out;
    logic       a_in;
    logic       g_in;
    logic       addsub;
    logic       done;
    logic       busy;
  } outs_t;

  outs_t act;
  always_comb act = {bus.ir_in, bus.r_in, bus.r_out, bus.din_out,
                     bus.g_out, bus.a_in, bus.g_in, bus.addsub,
                     bus.done, bus.busy};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, a, e, $time);
    end
  endtask

  // Micro-op table: list of per-cycle outputs an instruction produces
  outs_t exp_q[$];
  logic  in_t0 = 1'b1;

  function automatic logic [7:0] oh(input logic [2:0] i);
    logic [7:0] v;
    v = 8'd1 << i;
    return v;
  endfunction

  task automatic push_ins(input logic [8:0] ins);
    outs_t s;
    logic [2:0] op, x, y;
    op = ins[8:6];
    x  = ins[5:3];
    y  = ins[2:0];
    s = '0; s.busy = 1'b1;
    case (op)
      3'd0: begin
        s.r_out = oh(y); s.r_in = oh(x); s.done = 1'b1;
        exp_q.push_back(s);
      end
      3'd1: begin
        s.din_out = 1'b1; s.r_in = oh(x); s.done = 1'b1;
        exp_q.push_back(s);
      end
      3'd2, 3'd3: begin
        s.r_out = oh(x); s.a_in = 1'b1;
        exp_q.push_back(s);
        s = '0; s.busy = 1'b1;
        s.r_out = oh(y); s.g_in = 1'b1; s.addsub = (op == 3'd3);
        exp_q.push_back(s);
        s = '0; s.busy = 1'b1;
        s.g_out = 1'b1; s.r_in = oh(x); s.done = 1'b1;
        exp_q.push_back(s);
      end
      default: begin
        s.done = 1'b1;
        exp_q.push_back(s);
      end
    endcase
  endtask

  always @(negedge resetn) begin
    exp_q.delete();
    in_t0 = 1'b1;
  end

  // Datapath model driven by the controller outputs
  logic [15:0] dp_r [8];
  logic [15:0] dp_a, dp_g;

  always @(posedge clock) begin
    logic [15:0] b;
    if (resetn) begin
      if (in_t0 && bus.run) push_ins(bus.din[15:7]);
      b = '0;
      if (bus.din_out) b = bus.din;
      if (bus.g_out) b = dp_g;
      for (int i = 0; i < 8; i++) if (bus.r_out[i]) b = dp_r[i];
      if (bus.g_in) dp_g = bus.addsub ? dp_a - b : dp_a + b;
      if (bus.a_in) dp_a = b;
      for (int i = 0; i < 8; i++) if (bus.r_in[i]) dp_r[i] = b;
    end
  end

  always @(negedge clock) begin
    outs_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      in_t0 = 1'b0;
    end else begin
      e = '0;
      e.ir_in = bus.run;
      in_t0 = 1'b1;
    end
    chk("cycle_outputs", 32'(act), 32'(e));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [8:0] ins);
    bus.run = 1'b1;
    bus.din = {ins, 7'd0};
    step();
    bus.run = 1'b0;
  endtask

  int ir_cnt, dn_cnt;

  initial begin
    resetn  = 1'b0;
    bus.run = 1'b0;
    bus.din = '0;
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_ir_in_low", 32'(bus.ir_in), 32'd0);
    #2 bus.run = 1'b1;
    #1;
    chk("reset_ir_in_follows_run", 32'(bus.ir_in), 32'd1);
    bus.run = 1'b0;
    step();
    resetn = 1'b1;
    repeat (2) step();

    // mvi r0,#2
    fetch(9'b001_000_000);
    bus.din = 16'h0002;
    @(negedge clock);
    chk("mvi_t1", {bus.din_out, bus.r_in, bus.done}, {1'b1, 8'h01, 1'b1});
    step();
    chk("r0_eq_2", 32'(dp_r[0]), 32'd2);

    // mv r1,r0
    fetch(9'b000_001_000);
    @(negedge clock);
    chk("mv_t1", {bus.r_out, bus.r_in, bus.done}, {8'h01, 8'h02, 1'b1});
    step();
    chk("r1_eq_2", 32'(dp_r[1]), 32'd2);

    // mvi r1,#7 then add r1,r0
    fetch(9'b001_001_000);
    bus.din = 16'h0007;
    step();
    chk("r1_eq_7", 32'(dp_r[1]), 32'd7);
    fetch(9'b010_001_000);
    @(negedge clock);
    chk("add_t1", {bus.r_out, bus.a_in}, {8'h02, 1'b1});
    step();
    @(negedge clock);
    chk("add_t2", {bus.r_out, bus.g_in, bus.addsub}, {8'h01, 1'b1, 1'b0});
    step();
    @(negedge clock);
    chk("add_t3", {bus.g_out, bus.r_in, bus.done}, {1'b1, 8'h02, 1'b1});
    step();
    chk("r1_eq_9", 32'(dp_r[1]), 32'd9);

    // sub r1,r0 with a run pulse in T2
    fetch(9'b011_001_000);
    step();
    bus.run = 1'b1;
    @(negedge clock);
    chk("sub_t2", {bus.g_in, bus.addsub, bus.ir_in}, {1'b1, 1'b1, 1'b0});
    step();
    bus.run = 1'b0;
    step();
    chk("r1_eq_7_after_sub", 32'(dp_r[1]), 32'd7);
    @(negedge clock);
    chk("idle_after_sub", 32'(bus.busy), 32'd0);
    step();

    // reserved opcode with run held: refetch every other cycle
    bus.run = 1'b1;
    bus.din = {9'b101_000_000, 7'd0};
    ir_cnt = 0;
    dn_cnt = 0;
    repeat (8) begin
      @(negedge clock);
      ir_cnt += int'(bus.ir_in);
      dn_cnt += int'(bus.done);
    end
    chk("nop_ir_in_count", 32'(ir_cnt), 32'd4);
    chk("nop_done_count", 32'(dn_cnt), 32'd4);
    step();
    bus.run = 1'b0;
    step();

    // mvi r2,#5 then add r2,r2 back-to-back twice
    fetch(9'b001_010_000);
    bus.din = 16'h0005;
    step();
    bus.run = 1'b1;
    bus.din = {9'b010_010_010, 7'd0};
    ir_cnt = 0;
    repeat (8) begin
      @(negedge clock);
      ir_cnt += int'(bus.ir_in);
    end
    chk("add_issue_rate", 32'(ir_cnt), 32'd2);
    step();
    bus.run = 1'b0;
    chk("r2_eq_20", 32'(dp_r[2]), 32'd20);
    step();

    // reset during T2 of add r3,r3
    fetch(9'b001_011_000);
    bus.din = 16'h0009;
    step();
    fetch(9'b010_011_011);
    step();
    #1 resetn = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_enables", {bus.r_in, bus.r_out, bus.g_in}, 17'd0);
    step();
    resetn = 1'b1;
    repeat (3) step();
    chk("idle_after_reset", 32'(bus.busy), 32'd0);
    chk("r3_kept_9", 32'(dp_r[3]), 32'd9);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
